// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared definitions for the raster/pixel output stage:
//               default 640x480@60 timing, frame-size helper, RGB565 layout
//               and the default sync polarity.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Default 640x480 timing (pixel clocks / lines)
    localparam int c_h_visible     = 640;
    localparam int c_h_front       = 16;
    localparam int c_h_sync        = 96;
    localparam int c_h_back        = 48;
    localparam int c_v_visible     = 480;
    localparam int c_v_front       = 10;
    localparam int c_v_sync        = 2;
    localparam int c_v_back        = 33;

    // Clocks from x/y_coord to valid color out of the gpu
    localparam int c_pixel_latency = 2;

    // Counters are 10 bits wide, so neither total may exceed this
    localparam int c_max_total     = 1024;

    // Active level of hsync/vsync (VGA 640x480 uses negative syncs)
    localparam bit c_sync_active   = 1'b0;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic int calc_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
// Module      : pipe_delay
// Description : Resettable shift register of DEPTH stages, WIDTH bits each.
//               Every stage loads i_rst_val while rst is high. DEPTH == 0
//               is a plain wire.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_rst_val - value loaded into every stage on reset
//               i_din     - data in
//               o_dout    - data in, delayed DEPTH clocks
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_dout = i_din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= i_rst_val;
                    end
                end else begin
                    r_stage[0] <= i_din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// Module      : video_timing
// Description : Raster generator and pixel output stage for the rectangle
//               GPU. Drives x/y_coord to the gpu, takes RGB565 color back
//               PIXEL_LATENCY clocks later and emits VGA sync, data-enable
//               and RGB, all aligned. Pulses copy_start on the first
//               vertical-blanking line so the gpu can be refilled.
// Ports       : clk        - pixel clock
//               reset      - synchronous active-high reset
//               copy_start - one-cycle pulse at (h=0, v=V_VISIBLE)
//               x_coord    - current column (h counter)
//               y_coord    - current row (v counter)
//               color      - RGB565 from gpu, PIXEL_LATENCY clocks after coords
//               vga_hsync  - horizontal sync
//               vga_vsync  - vertical sync
//               vga_de     - data enable
//               vga_r/g/b  - 5/6/5 pixel color, zero during blanking
// Options     : VIDEO_TEST_PATTERN_EN - when defined, color is ignored and
//               active video shows 8 vertical color bars.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing
    import video_pkg::*;
#(
    parameter int H_VISIBLE     = c_h_visible,
    parameter int H_FRONT       = c_h_front,
    parameter int H_SYNC        = c_h_sync,
    parameter int H_BACK        = c_h_back,
    parameter int V_VISIBLE     = c_v_visible,
    parameter int V_FRONT       = c_v_front,
    parameter int V_SYNC        = c_v_sync,
    parameter int V_BACK        = c_v_back,
    parameter int PIXEL_LATENCY = c_pixel_latency,
    parameter bit SYNC_ACTIVE   = c_sync_active
) (
    input  logic        clk,
    input  logic        reset,
    output logic        copy_start,
    output logic [9:0]  x_coord,
    output logic [9:0]  y_coord,
    input  logic [15:0] color,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [4:0]  vga_r,
    output logic [5:0]  vga_g,
    output logic [4:0]  vga_b
);

    localparam int c_h_total = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int c_v_total = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    generate
        if (c_h_total > c_max_total) begin : g_h_total_chk
            $error("video_timing: H_TOTAL %0d exceeds %0d", c_h_total, c_max_total);
        end
        if (c_v_total > c_max_total) begin : g_v_total_chk
            $error("video_timing: V_TOTAL %0d exceeds %0d", c_v_total, c_max_total);
        end
        if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 7) begin : g_latency_chk
            $error("video_timing: PIXEL_LATENCY %0d outside 0..7", PIXEL_LATENCY);
        end
    endgenerate

    localparam logic [9:0]  c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0]  c_cs_line  = 10'(V_VISIBLE);
    // Window bounds are 11 bits so an end bound of exactly 1024 still compares correctly
    localparam logic [10:0] c_h_vis    = 11'(H_VISIBLE);
    localparam logic [10:0] c_hs_beg   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_end   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_v_vis    = 11'(V_VISIBLE);
    localparam logic [10:0] c_vs_beg   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_vs_end   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign x_coord    = r_h_cnt;
    assign y_coord    = r_v_cnt;
    assign copy_start = (r_h_cnt == 10'd0) && (r_v_cnt == c_cs_line);

    // ------------------------------------------------------------------------
    // Raw (coordinate-time) control, delayed to line up with the gpu color
    // ------------------------------------------------------------------------
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_de_raw;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [2:0]  w_ctl_dly;

    assign w_h      = {1'b0, r_h_cnt};
    assign w_v      = {1'b0, r_v_cnt};
    assign w_de_raw = (w_h < c_h_vis) && (w_v < c_v_vis);
    assign w_hs_raw = ((w_h >= c_hs_beg) && (w_h < c_hs_end)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign w_vs_raw = ((w_v >= c_vs_beg) && (w_v < c_vs_end)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // After PIXEL_LATENCY stages the control bits sit alongside the color
    // the gpu is returning for the same coordinate; one more register below
    // produces the outputs.
    pipe_delay #(
        .WIDTH (3),
        .DEPTH (PIXEL_LATENCY)
    ) u_ctl_dly (
        .clk       (clk),
        .rst       (reset),
        .i_rst_val ({1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE}),
        .i_din     ({w_de_raw, w_hs_raw, w_vs_raw}),
        .o_dout    (w_ctl_dly)
    );

    // ------------------------------------------------------------------------
    // Pixel source
    // ------------------------------------------------------------------------
    rgb565_t w_pix;

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int c_bar_w = H_VISIBLE / 8;

    logic [2:0] w_bar;
    logic [2:0] w_bar_dly;

    // Highest threshold crossed gives the bar index; avoids a divider when
    // the bar width is not a power of two.
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_h >= 11'(i * c_bar_w)) begin
                w_bar = 3'(i);
            end
        end
    end

    // Same latency as the gpu path so bars land on the right pixels
    pipe_delay #(
        .WIDTH (3),
        .DEPTH (PIXEL_LATENCY)
    ) u_bar_dly (
        .clk       (clk),
        .rst       (reset),
        .i_rst_val (3'd0),
        .i_din     (w_bar),
        .o_dout    (w_bar_dly)
    );

    always_comb begin
        w_pix.r = w_bar_dly[2] ? 5'h1F : 5'h00;
        w_pix.g = w_bar_dly[1] ? 6'h3F : 6'h00;
        w_pix.b = w_bar_dly[0] ? 5'h1F : 5'h00;
    end
`else
    assign w_pix = rgb565_t'(color);
`endif

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    logic    r_de;
    logic    r_hs;
    logic    r_vs;
    rgb565_t r_rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_de  <= 1'b0;
            r_hs  <= ~SYNC_ACTIVE;
            r_vs  <= ~SYNC_ACTIVE;
            r_rgb <= '0;
        end else begin
            {r_de, r_hs, r_vs} <= w_ctl_dly;
            // Blanking forces black regardless of what the gpu drives
            r_rgb <= w_ctl_dly[2] ? w_pix : '0;
        end
    end

    assign vga_de    = r_de;
    assign vga_hsync = r_hs;
    assign vga_vsync = r_vs;
    assign vga_r     = r_rgb.r;
    assign vga_g     = r_rgb.g;
    assign vga_b     = r_rgb.b;

endmodule
`default_nettype wire
